// File: rtl/hp_pkg.sv
// Shared types and constants for the two-player HP / round controller.
package hp_pkg;
  localparam int HP_W = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIGHT = 2'd1,
    KO    = 2'd2
  } hp_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
endpackage

// File: rtl/hp_invuln_timer.sv
// Per-player invulnerability window, counted in frame ticks.
module hp_invuln_timer #(
  parameter int INVULN_FRAMES = 30
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_tick,
  output logic o_busy
);
  localparam int CW = $clog2(INVULN_FRAMES + 1);

  logic [CW-1:0] r_cnt, w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr)                        w_cnt_nxt = '0;
    else if (i_load)                  w_cnt_nxt = CW'(INVULN_FRAMES);
    else if (i_tick && r_cnt != '0)   w_cnt_nxt = r_cnt - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= w_cnt_nxt;
  end

  // Busy as of the next cycle, so the registered ready in the top lines up with the count.
  assign o_busy = (w_cnt_nxt != '0);
endmodule

// File: rtl/hp_controller.sv
// Two-player HP registers, hit handshake, invulnerability and round FSM (IDLE/FIGHT/KO).
module hp_controller
  import hp_pkg::*;
#(
  parameter int TOTAL_HP      = 20,
  parameter int DMG_W         = 5,
  parameter int INVULN_FRAMES = 30,
  parameter int KO_FRAMES     = 120
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_clk,
  input  logic            start_round,
  input  logic            hit1_valid,
  input  logic [DMG_W-1:0] hit1_dmg,
  output logic            hit1_ready,
  input  logic            hit2_valid,
  input  logic [DMG_W-1:0] hit2_dmg,
  output logic            hit2_ready,
  output logic [HP_W-1:0] hp1,
  output logic [HP_W-1:0] hp2,
  output logic            exist_hp,
  output logic [1:0]      winner,
  output logic            round_over
);
  localparam int KW = $clog2(KO_FRAMES + 1);

  hp_state_t r_state, w_state_nxt;

  logic                  r_fs1, r_fs2, r_fs_prev;
  logic                  w_tick, w_start, w_ko_done;
  logic [1:0]            w_valid, w_acc, w_ko, w_busy;
  logic [1:0][DMG_W-1:0] w_dmg;
  logic [1:0][HP_W-1:0]  r_hp, w_hp_nxt;
  logic [1:0]            r_ready;
  logic                  r_exist, r_round_over;
  logic [1:0]            r_winner;
  logic [KW-1:0]         r_ko_cnt;

  // Two-flop sampler plus a previous-value flop: tick trails frame_clk by two cycles.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_fs1     <= 1'b0;
      r_fs2     <= 1'b0;
      r_fs_prev <= 1'b0;
    end else begin
      r_fs1     <= frame_clk;
      r_fs2     <= r_fs1;
      r_fs_prev <= r_fs2;
    end
  end
  assign w_tick = r_fs2 & ~r_fs_prev;

  assign w_valid   = {hit2_valid, hit1_valid};
  assign w_dmg     = {hit2_dmg, hit1_dmg};
  assign w_acc     = w_valid & r_ready;
  assign w_start   = start_round && (r_state == IDLE);
  assign w_ko_done = (r_state == KO) && w_tick && (r_ko_cnt == KW'(KO_FRAMES - 1));

  for (genvar g = 0; g < 2; g++) begin : g_player
    logic [HP_W:0] w_diff;
    logic [HP_W-1:0] w_sat;

    // Top bit of the widened difference is the borrow; it clamps at zero.
    assign w_diff      = {1'b0, r_hp[g]} - {{(HP_W + 1 - DMG_W){1'b0}}, w_dmg[g]};
    assign w_sat       = w_diff[HP_W] ? '0 : w_diff[HP_W-1:0];
    assign w_hp_nxt[g] = w_acc[g] ? w_sat : r_hp[g];
    assign w_ko[g]     = w_acc[g] && (w_sat == '0);

    hp_invuln_timer #(.INVULN_FRAMES(INVULN_FRAMES)) u_timer (
      .i_clk   (Clk),
      .i_rst_n (Reset),
      .i_clr   (w_start),
      .i_load  (w_acc[g]),
      .i_tick  (w_tick),
      .o_busy  (w_busy[g])
    );
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start)   w_state_nxt = FIGHT;
      FIGHT:   if (|w_ko)     w_state_nxt = KO;
      KO:      if (w_ko_done) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_hp         <= {2{HP_W'(TOTAL_HP)}};
      r_winner     <= WIN_NONE;
      r_ready      <= '0;
      r_exist      <= 1'b0;
      r_round_over <= 1'b0;
      r_ko_cnt     <= '0;
    end else begin
      if (w_start) begin
        r_hp     <= {2{HP_W'(TOTAL_HP)}};
        r_winner <= WIN_NONE;
      end else if (r_state == FIGHT) begin
        r_hp <= w_hp_nxt;
        // hp1 reaching zero means player 2 wins, hence the bit swap.
        if (|w_ko) r_winner <= {w_ko[0], w_ko[1]};
      end
      for (int i = 0; i < 2; i++)
        r_ready[i] <= (w_state_nxt == FIGHT) && !w_busy[i];
      r_exist      <= (w_state_nxt != IDLE);
      r_round_over <= w_ko_done;
      if (r_state != KO) r_ko_cnt <= '0;
      else if (w_tick)   r_ko_cnt <= r_ko_cnt + 1'b1;
    end
  end

  assign hp1        = r_hp[0];
  assign hp2        = r_hp[1];
  assign hit1_ready = r_ready[0];
  assign hit2_ready = r_ready[1];
  assign exist_hp   = r_exist;
  assign winner     = r_winner;
  assign round_over = r_round_over;
endmodule
